// File: rtl/eq_audio_pkg.sv
// Shared audio constants for the equalizer chain: sample width, channel-select codes
// and the I2S receiver's frame-tracking states.
`timescale 1ns/1ps
package eq_audio_pkg;
   localparam int AUDIO_WIDTH = 24;

   localparam int CH_LEFT  = 0;
   localparam int CH_RIGHT = 1;
   localparam int CH_MIX   = 2;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LEFT     = 2'd1,
      RIGHT    = 2'd2
   } rx_state_t;
endpackage

// File: rtl/i2s_rx_deserializer_sync_edge.sv
// Brings sck/ws/sd into clk through 2-FF synchronisers; emits a one-clk sck_rise with ws/sd
// registered alongside so all three stay aligned. Latency 3 clk from pin; no backpressure.
`timescale 1ns/1ps
module i2s_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i2s_sck,
   input  logic i2s_ws,
   input  logic i2s_sd,
   output logic sck_rise,
   output logic ws_s,
   output logic sd_s
);
   logic [1:0] sck_ff;
   logic [1:0] ws_ff;
   logic [1:0] sd_ff;
   logic       sck_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_ff   <= '0;
         ws_ff    <= '0;
         sd_ff    <= '0;
         sck_d    <= 1'b0;
         sck_rise <= 1'b0;
         ws_s     <= 1'b0;
         sd_s     <= 1'b0;
      end else begin
         sck_ff   <= {sck_ff[0], i2s_sck};
         ws_ff    <= {ws_ff[0], i2s_ws};
         sd_ff    <= {sd_ff[0], i2s_sd};
         sck_d    <= sck_ff[1];
         sck_rise <= sck_ff[1] & ~sck_d;
         ws_s     <= ws_ff[1];
         sd_s     <= sd_ff[1];
      end
   end
endmodule

// File: rtl/i2s_rx_deserializer.sv
// Slave-mode I2S receiver: one signed mono sample per stereo frame with a one-clk strobe,
// 4 clk after the closing SCK rise at the pin. No backpressure; framing faults pulse frame_err.
`timescale 1ns/1ps
module i2s_rx_deserializer
   import eq_audio_pkg::*;
#(
   parameter int DATA_WIDTH = AUDIO_WIDTH,
   parameter int MAX_SLOT   = 32,
   parameter int CH_SEL     = CH_MIX
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i2s_sck,
   input  logic                  i2s_ws,
   input  logic                  i2s_sd,
   output logic [DATA_WIDTH-1:0] sample_out,
   output logic                  sample_valid,
   output logic                  frame_err,
   output logic                  locked
);
   localparam int CW = $clog2(MAX_SLOT + 1);
   localparam int IW = $clog2(DATA_WIDTH);

   logic                  sck_rise;
   logic                  ws_s;
   logic                  sd_s;
   logic                  ws_prev;
   rx_state_t             state;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] left_q;

   logic [IW-1:0]         idx_c;
   logic [DATA_WIDTH-1:0] word_c;
   logic [DATA_WIDTH:0]   sum_c;
   logic [DATA_WIDTH-1:0] sel_c;
   logic [CW-1:0]         cnt_inc;
   logic                  timeout_c;
   logic                  short_c;

   i2s_sync_edge u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .i2s_sck  (i2s_sck),
      .i2s_ws   (i2s_ws),
      .i2s_sd   (i2s_sd),
      .sck_rise (sck_rise),
      .ws_s     (ws_s),
      .sd_s     (sd_s)
   );

   // Bits land left-justified by position, so a short slot leaves its missing LSBs at zero.
   always_comb begin
      word_c = shift_q;
      idx_c  = IW'(DATA_WIDTH - 1) - IW'(bit_cnt);
      if (bit_cnt < CW'(DATA_WIDTH))
         word_c[idx_c] = sd_s;
      sum_c     = {left_q[DATA_WIDTH-1], left_q} + {word_c[DATA_WIDTH-1], word_c};
      sel_c     = sum_c[DATA_WIDTH:1];
      if (CH_SEL == CH_LEFT)
         sel_c = left_q;
      else if (CH_SEL == CH_RIGHT)
         sel_c = word_c;
      cnt_inc   = (bit_cnt == CW'(MAX_SLOT)) ? bit_cnt : bit_cnt + 1'b1;
      timeout_c = (bit_cnt == CW'(MAX_SLOT - 1));
      short_c   = (bit_cnt < CW'(DATA_WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= UNLOCKED;
         ws_prev      <= 1'b0;
         bit_cnt      <= '0;
         shift_q      <= '0;
         left_q       <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         locked       <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         if (sck_rise) begin
            ws_prev <= ws_s;
            if (ws_s != ws_prev) begin
               // The bit on a WS change still belongs to the slot that is closing.
               bit_cnt <= '0;
               shift_q <= '0;
               case (state)
                  UNLOCKED: begin
                     if (!ws_s) begin
                        state  <= LEFT;
                        locked <= 1'b1;
                     end
                  end
                  LEFT: begin
                     left_q    <= word_c;
                     state     <= RIGHT;
                     frame_err <= short_c;
                  end
                  RIGHT: begin
                     sample_out   <= sel_c;
                     sample_valid <= 1'b1;
                     state        <= LEFT;
                     frame_err    <= short_c;
                  end
                  default: begin
                     state  <= UNLOCKED;
                     locked <= 1'b0;
                  end
               endcase
            end else begin
               bit_cnt <= cnt_inc;
               shift_q <= word_c;
               if (timeout_c) begin
                  frame_err <= 1'b1;
                  state     <= UNLOCKED;
                  locked    <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench: two receivers (left-only and mono-mix) on one I2S stream, scoreboarded.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;
   import eq_audio_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i2s_sck = 1'b0;
   logic        i2s_ws = 1'b1;
   logic        i2s_sd = 1'b0;
   logic [23:0] out0, out2;
   logic        vld0, vld2, err0, err2, lck0, lck2;

   int          half = 40;
   int          checks = 0;
   int          errors = 0;
   int          strobes0 = 0;
   int          errpulses = 0;
   logic [23:0] q0[$];
   logic [23:0] q2[$];
   logic [23:0] prev0 = '0;
   logic [23:0] prev2 = '0;

   always #5 clk = ~clk;

   i2s_rx_deserializer #(.DATA_WIDTH(24), .MAX_SLOT(32), .CH_SEL(CH_LEFT)) dut0 (
      .clk(clk), .rst_n(rst_n), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
      .sample_out(out0), .sample_valid(vld0), .frame_err(err0), .locked(lck0)
   );

   i2s_rx_deserializer #(.DATA_WIDTH(24), .MAX_SLOT(32), .CH_SEL(CH_MIX)) dut2 (
      .clk(clk), .rst_n(rst_n), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
      .sample_out(out2), .sample_valid(vld2), .frame_err(err2), .locked(lck2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] mix(input logic [23:0] l, input logic [23:0] r);
      int s;
      s = int'($signed(l)) + int'($signed(r));
      return 24'(s >>> 1);
   endfunction

   always @(negedge clk) begin
      if (vld0) begin
         strobes0++;
         check("strobe expected ch0", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) check("sample ch0", 32'(out0), 32'(q0.pop_front()));
      end
      if (vld2) begin
         check("strobe expected mix", 32'(q2.size() != 0), 32'd1);
         if (q2.size() != 0) check("sample mix", 32'(out2), 32'(q2.pop_front()));
      end
      if (rst_n && out0 !== prev0) check("ch0 changes only with valid", 32'(vld0), 32'd1);
      if (rst_n && out2 !== prev2) check("mix changes only with valid", 32'(vld2), 32'd1);
      prev0 = out0;
      prev2 = out2;
      if (err0) errpulses++;
   end

   task automatic sck_edge(input logic ws, input logic sd);
      i2s_ws = ws;
      i2s_sd = sd;
      #(half) i2s_sck = 1'b1;
      #(half) i2s_sck = 1'b0;
   endtask

   task automatic send_slot(input logic [23:0] w, input int slot, input logic ws);
      logic [23:0] sh;
      logic        b;
      sh = w;
      for (int k = 0; k < slot; k++) begin
         b  = (k < 24) ? sh[23] : 1'($urandom_range(0, 1));
         sh = sh << 1;
         sck_edge((k == slot - 1) ? ~ws : ws, b);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int slot);
      logic [23:0] m;
      m = (slot >= 24) ? 24'hFFFFFF : 24'(~((32'h1 << (24 - slot)) - 1));
      q0.push_back(l & m);
      q2.push_back(mix(l & m, r & m));
      send_slot(l, slot, 1'b0);
      send_slot(r, slot, 1'b1);
   endtask

   task automatic lead_in();
      repeat (4) sck_edge(1'b1, 1'($urandom_range(0, 1)));
      sck_edge(1'b0, 1'($urandom_range(0, 1)));
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((q0.size() != 0 || q2.size() != 0) && n < 400) begin
         @(posedge clk);
         n++;
      end
      check(tag, 32'(q0.size() + q2.size()), 32'd0);
      repeat (8) @(posedge clk);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_s, base_e;

      repeat (3) @(posedge clk);
      #1;
      check("reset sample_out ch0", 32'(out0), 32'd0);
      check("reset sample_valid", 32'(vld0), 32'd0);
      check("reset frame_err", 32'(err0), 32'd0);
      check("reset locked ch0", 32'(lck0), 32'd0);
      check("reset sample_out mix", 32'(out2), 32'd0);
      check("reset locked mix", 32'(lck2), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Basic 32-bit frames, left channel and mix
      lead_in();
      check("locked after lead-in", 32'(lck0), 32'd1);
      repeat (3) send_frame(24'h123456, 24'h654321, 32);
      drain("drain basic");
      check("strobes after 3 frames", 32'(strobes0), 32'd3);
      check("locked after frames", 32'(lck0), 32'd1);
      check("no errors on clean frames", 32'(errpulses), 32'd0);

      // Mix extremes
      send_frame(24'h800000, 24'h7FFFFF, 32);
      send_frame(24'h7FFFFF, 24'h7FFFFF, 32);
      drain("drain mix");
      check("strobes after mix frames", 32'(strobes0), 32'd5);

      // 20-bit short slots
      base_e = errpulses;
      send_frame(24'hABCDE0, 24'h123450, 20);
      send_frame(24'hABCDE0, 24'h543210, 20);
      drain("drain short slots");
      check("short-slot error pulses", 32'(errpulses - base_e), 32'd4);
      check("locked through short slots", 32'(lck0), 32'd1);

      // WS stuck low: fault on the 32nd edge, then relock
      base_e = errpulses;
      repeat (31) sck_edge(1'b0, 1'($urandom_range(0, 1)));
      repeat (4) @(posedge clk);
      check("no fault before edge 32", 32'(errpulses - base_e), 32'd0);
      check("still locked before edge 32", 32'(lck0), 32'd1);
      sck_edge(1'b0, 1'b0);
      repeat (4) @(posedge clk);
      check("fault at edge 32", 32'(errpulses - base_e), 32'd1);
      repeat (8) sck_edge(1'b0, 1'($urandom_range(0, 1)));
      check("unlocked after ws stuck", 32'(lck0), 32'd0);
      check("single fault pulse", 32'(errpulses - base_e), 32'd1);
      lead_in();
      send_frame(24'h0A0B0C, 24'hF0E0D0, 32);
      drain("drain relock");
      check("relocked", 32'(lck0), 32'd1);
      check("no extra fault on relock", 32'(errpulses - base_e), 32'd1);

      // Reset mid-right-slot
      base_s = strobes0;
      send_slot(24'h111111, 32, 1'b0);
      repeat (10) sck_edge(1'b1, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset sample_out ch0", 32'(out0), 32'd0);
      check("async reset sample_out mix", 32'(out2), 32'd0);
      check("async reset locked", 32'(lck0), 32'd0);
      check("async reset valid", 32'(vld0), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (21) sck_edge(1'b1, 1'($urandom_range(0, 1)));
      sck_edge(1'b0, 1'($urandom_range(0, 1)));
      send_frame(24'h222222, 24'h333333, 32);
      drain("drain after reset");
      check("one strobe after mid-frame reset", 32'(strobes0 - base_s), 32'd1);

      // SCK = clk/4, stream starting mid-right-slot
      half = 20;
      pulse_reset();
      base_s = strobes0;
      repeat (7) sck_edge(1'b1, 1'($urandom_range(0, 1)));
      sck_edge(1'b0, 1'($urandom_range(0, 1)));
      send_frame(24'($urandom), 24'($urandom), 32);
      send_frame(24'($urandom), 24'($urandom), 32);
      drain("drain fast sck");
      check("strobes at fast sck", 32'(strobes0 - base_s), 32'd2);
      check("locked at fast sck", 32'(lck0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
